wb_mem_slave: RTL and testbench

Parametrised, synthesizable Wishbone-classic memory slave replacing the ad-hoc memory model in the single-core picorv32 bench. It holds a byte-writable word RAM, answers single transfers after a configurable number of wait states, and exposes a sticky halt flag raised by a firmware "exit" write. It sits between `picorv32_top`'s bus and the bench or FPGA top, on the same clock as the core.

---
 rtl/wb_mem_pkg.sv | 14 +
 rtl/wb_mem_slave_if.sv | 24 ++
 rtl/wb_mem_array.sv | 50 +++++
 rtl/wb_mem_slave.sv | 156 +++++++++++++++
 tb/tb_wb_mem_slave.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/wb_mem_pkg.sv
// Shared types and defaults for the Wishbone-classic memory slave.
package wb_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int          WS_W          = 4;
    localparam logic [29:0] HALT_ADDR_DEF = 30'h0400_0001;
    localparam logic [31:0] HALT_CODE_DEF = 32'h0000_00ad;

endpackage

// File: rtl/wb_mem_slave_if.sv
// Wishbone-classic bus bundle between a master and wb_mem_slave.
// The err line and its modport entries exist only when WB_MEM_ERR_EN is defined.
interface wb_mem_slave_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 30
);
    logic [ADDR_W-1:0]   adr;
    logic [DATA_W-1:0]   dat;
    logic [DATA_W/8-1:0] sel;
    logic                we;
    logic                cyc;
    logic                stb;
    logic [DATA_W-1:0]   rdt;
    logic                ack;
`ifdef WB_MEM_ERR_EN
    logic                err;

    modport master (output adr, dat, sel, we, cyc, stb, input rdt, ack, err);
    modport slave  (input adr, dat, sel, we, cyc, stb, output rdt, ack, err);
`else
    modport master (output adr, dat, sel, we, cyc, stb, input rdt, ack);
    modport slave  (input adr, dat, sel, we, cyc, stb, output rdt, ack);
`endif
endinterface

// File: rtl/wb_mem_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module wb_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32768
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     re,
    input  logic [DATA_W/8-1:0]      be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);
    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Byte-lane writes; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Read data captured only on a read strobe, held otherwise.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/wb_mem_slave.sv
// Wishbone-classic memory slave with wait states and a sticky halt register.
// Define WB_MEM_ERR_EN to error-acknowledge out-of-range accesses instead of aliasing them.
module wb_mem_slave
    import wb_mem_pkg::*;
#(
    parameter int                 DATA_W      = 32,
    parameter int                 ADDR_W      = 30,
    parameter int                 DEPTH       = 32768,
    parameter int                 WAIT_STATES = 1,
    parameter logic [ADDR_W-1:0]  HALT_ADDR   = ADDR_W'(HALT_ADDR_DEF),
    parameter logic [DATA_W-1:0]  HALT_CODE   = DATA_W'(HALT_CODE_DEF)
) (
    input  logic           clk,
    input  logic           resetn,
    wb_mem_slave_if.slave  bus,
    output logic           halt
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = DATA_W / 8;

    state_e              state_q, state_d;
    logic [WS_W-1:0]     cnt_q, cnt_d;
    logic                ack_q, ack_d;
    logic                halt_q, halt_d;
    logic                rd_ram_q, rd_ram_d;
    logic [DATA_W-1:0]   rd_val_q, rd_val_d;

    logic                req_s;
    logic                go_resp_s;
    logic                is_halt_s;
    logic                halt_hit_s;
    logic                oor_s;
    logic                ram_re_s;
    logic [NB-1:0]       ram_be_s;
    logic [DATA_W-1:0]   ram_rdata_s;

    assign req_s      = bus.cyc & bus.stb;
    assign is_halt_s  = (bus.adr == HALT_ADDR);
    assign halt_hit_s = is_halt_s & bus.we & (&bus.sel) & (bus.dat == HALT_CODE);

`ifdef WB_MEM_ERR_EN
    logic err_q, err_d;
    logic in_range_s;

    assign in_range_s = ((bus.adr >> AW) == '0);
    assign oor_s      = ~in_range_s & ~is_halt_s;
    assign err_d      = go_resp_s & oor_s;
    assign bus.err    = err_q;

    // Error acknowledge pulse register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign oor_s = 1'b0;
`endif

    // Transfer FSM; go_resp_s marks the edge that enters RESP (commit point).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        go_resp_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    cnt_d = WS_W'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_d   = ST_RESP;
                        go_resp_s = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!req_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == WS_W'(1)) begin
                    state_d   = ST_RESP;
                    go_resp_s = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q - WS_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Decode and response data selection, evaluated on the live bus.
    always_comb begin
        ram_be_s = (go_resp_s & bus.we & ~is_halt_s & ~oor_s) ? bus.sel : '0;
        ram_re_s = go_resp_s & ~bus.we & ~is_halt_s & ~oor_s;
        ack_d    = go_resp_s & ~oor_s;
        halt_d   = halt_q | (go_resp_s & halt_hit_s);
        rd_ram_d = rd_ram_q;
        rd_val_d = rd_val_q;
        if (go_resp_s & ~bus.we) begin
            rd_ram_d = ~is_halt_s & ~oor_s;
            rd_val_d = is_halt_s ? {{(DATA_W-1){1'b0}}, halt_q} : '0;
        end else begin
            rd_ram_d = rd_ram_q;
            rd_val_d = rd_val_q;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ack_q    <= 1'b0;
            halt_q   <= 1'b0;
            rd_ram_q <= 1'b0;
            rd_val_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            halt_q   <= halt_d;
            rd_ram_q <= rd_ram_d;
            rd_val_q <= rd_val_d;
        end
    end

    wb_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .rst_n (resetn),
        .re    (ram_re_s),
        .be    (ram_be_s),
        .addr  (bus.adr[AW-1:0]),
        .wdata (bus.dat),
        .rdata (ram_rdata_s)
    );

    assign bus.rdt = rd_ram_q ? ram_rdata_s : rd_val_q;
    assign bus.ack = ack_q;
    assign halt    = halt_q;

endmodule

// File: tb/tb_wb_mem_slave.sv
// Directed bench for wb_mem_slave: three instances with 0, 1 and 3 wait states.
module tb_wb_mem_slave;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [29:0] adr = 30'h0;
    logic [31:0] dat = 32'h0;
    logic [3:0]  sel = 4'h0;
    logic        we  = 1'b0;
    logic [2:0]  cyc_v = 3'b000;
    logic        halt_w0, halt_w1, halt_w3;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    wb_mem_slave_if #(.DATA_W(32), .ADDR_W(30)) bus_w0 ();
    wb_mem_slave_if #(.DATA_W(32), .ADDR_W(30)) bus_w1 ();
    wb_mem_slave_if #(.DATA_W(32), .ADDR_W(30)) bus_w3 ();

    assign bus_w0.adr = adr; assign bus_w0.dat = dat; assign bus_w0.sel = sel; assign bus_w0.we = we;
    assign bus_w1.adr = adr; assign bus_w1.dat = dat; assign bus_w1.sel = sel; assign bus_w1.we = we;
    assign bus_w3.adr = adr; assign bus_w3.dat = dat; assign bus_w3.sel = sel; assign bus_w3.we = we;
    assign bus_w0.cyc = cyc_v[0]; assign bus_w0.stb = cyc_v[0];
    assign bus_w1.cyc = cyc_v[1]; assign bus_w1.stb = cyc_v[1];
    assign bus_w3.cyc = cyc_v[2]; assign bus_w3.stb = cyc_v[2];

    wb_mem_slave #(.WAIT_STATES(0)) u_w0 (.clk(clk), .resetn(resetn), .bus(bus_w0), .halt(halt_w0));
    wb_mem_slave #(.WAIT_STATES(1)) u_w1 (.clk(clk), .resetn(resetn), .bus(bus_w1), .halt(halt_w1));
    wb_mem_slave #(.WAIT_STATES(3)) u_w3 (.clk(clk), .resetn(resetn), .bus(bus_w3), .halt(halt_w3));

    function automatic logic get_ack(input int k);
        case (k)
            0:       return bus_w0.ack;
            1:       return bus_w1.ack;
            default: return bus_w3.ack;
        endcase
    endfunction

    function automatic logic [31:0] get_rdt(input int k);
        case (k)
            0:       return bus_w0.rdt;
            1:       return bus_w1.rdt;
            default: return bus_w3.rdt;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transfer on instance k (0:W0, 1:W1, 2:W3); lat counts edges from request to ack.
    task automatic xfer(input int k, input logic [29:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic w,
                        output int lat, output logic [31:0] rd);
        adr = a; dat = d; sel = s; we = w;
        cyc_v[k] = 1'b1;
        lat = 99;
        rd  = 32'h0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (get_ack(k)) begin
                lat = i;
                rd  = get_rdt(k);
                break;
            end
        end
        cyc_v[k] = 1'b0;
        we = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic [5:0]  pat;
        logic        any_ack;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_ack", {31'h0, bus_w1.ack}, 32'h0);
        check("reset_rdt", bus_w1.rdt, 32'h0);
        check("reset_halt", {31'h0, halt_w1}, 32'h0);
        resetn = 1'b1;
        @(negedge clk);

        // W=1 full-word write then read
        xfer(1, 30'h10, 32'hDEADBEEF, 4'hF, 1'b1, lat, rd);
        check("w1_wr_latency", 32'(lat), 32'd2);
        xfer(1, 30'h10, 32'h0, 4'hF, 1'b0, lat, rd);
        check("w1_rd_latency", 32'(lat), 32'd2);
        check("w1_rd_data", rd, 32'hDEADBEEF);
        check("w1_ack_pulse", {31'h0, bus_w1.ack}, 32'h0);
        check("w1_rdt_hold", bus_w1.rdt, 32'hDEADBEEF);

        // Byte lanes
        xfer(1, 30'h20, 32'hFFFFFFFF, 4'hF, 1'b1, lat, rd);
        xfer(1, 30'h20, 32'h11223344, 4'b0101, 1'b1, lat, rd);
        xfer(1, 30'h20, 32'h0, 4'hF, 1'b0, lat, rd);
        check("byte_lanes", rd, 32'hFF22FF44);

        // W=0 with request held: ack, idle, ack, ...
        adr = 30'h30; dat = 32'hA5A50001; sel = 4'hF; we = 1'b1;
        cyc_v[0] = 1'b1;
        pat = 6'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pat = {pat[4:0], bus_w0.ack};
        end
        cyc_v[0] = 1'b0; we = 1'b0;
        @(negedge clk);
        check("w0_ack_pattern", {26'h0, pat}, 32'h0000002A);
        xfer(0, 30'h30, 32'h0, 4'hF, 1'b0, lat, rd);
        check("w0_rd_latency", 32'(lat), 32'd1);
        check("w0_rd_data", rd, 32'hA5A50001);

        // W=3 abort mid-WAIT
        xfer(2, 30'h40, 32'h12345678, 4'hF, 1'b1, lat, rd);
        check("w3_wr_latency", 32'(lat), 32'd4);
        adr = 30'h40; dat = 32'hCAFEF00D; sel = 4'hF; we = 1'b1;
        cyc_v[2] = 1'b1;
        repeat (2) @(negedge clk);
        cyc_v[2] = 1'b0; we = 1'b0;
        any_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            any_ack = any_ack | bus_w3.ack;
        end
        check("abort_no_ack", {31'h0, any_ack}, 32'h0);
        xfer(2, 30'h40, 32'h0, 4'hF, 1'b0, lat, rd);
        check("abort_word_kept", rd, 32'h12345678);

        // Halt register (aliases word 1 in the low address bits)
        xfer(1, 30'h1, 32'h00000055, 4'hF, 1'b1, lat, rd);
        xfer(1, 30'h0400_0001, 32'h000000AC, 4'hF, 1'b1, lat, rd);
        check("halt_wrong_code_ack", 32'(lat), 32'd2);
        check("halt_wrong_code", {31'h0, halt_w1}, 32'h0);
        adr = 30'h0400_0001; dat = 32'h000000AD; sel = 4'hF; we = 1'b1;
        cyc_v[1] = 1'b1;
        @(negedge clk);
        check("halt_before_ack", {30'h0, bus_w1.ack, halt_w1}, 32'h0);
        @(negedge clk);
        check("halt_with_ack", {30'h0, bus_w1.ack, halt_w1}, 32'h3);
        cyc_v[1] = 1'b0; we = 1'b0;
        @(negedge clk);
        xfer(1, 30'h1, 32'h0, 4'hF, 1'b0, lat, rd);
        check("halt_ram_untouched", rd, 32'h00000055);
        xfer(1, 30'h0400_0001, 32'h0, 4'hF, 1'b0, lat, rd);
        check("halt_readback", rd, 32'h00000001);

        // Reset asserted during RESP
        adr = 30'h10; we = 1'b0; sel = 4'hF;
        cyc_v[1] = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_resp_ack_before", {31'h0, bus_w1.ack}, 32'h1);
        resetn = 1'b0;
        #1;
        check("rst_async_ack", {31'h0, bus_w1.ack}, 32'h0);
        check("rst_async_rdt", bus_w1.rdt, 32'h0);
        check("rst_halt_clear", {31'h0, halt_w1}, 32'h0);
        cyc_v[1] = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

`ifdef WB_MEM_ERR_EN
        // Out-of-range read: err instead of ack
        adr = 30'h8000; we = 1'b0; sel = 4'hF;
        cyc_v[1] = 1'b1;
        repeat (2) @(negedge clk);
        check("oor_err", {30'h0, bus_w1.err, bus_w1.ack}, 32'h2);
        check("oor_rdt_zero", bus_w1.rdt, 32'h0);
        cyc_v[1] = 1'b0;
        @(negedge clk);
`else
        // Out-of-range write aliases onto the low address bits
        xfer(1, 30'h8010, 32'h0BADF00D, 4'hF, 1'b1, lat, rd);
        check("alias_wr_ack", 32'(lat), 32'd2);
        xfer(1, 30'h10, 32'h0, 4'hF, 1'b0, lat, rd);
        check("alias_rd_data", rd, 32'h0BADF00D);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
